// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD clock types, option codes, field limits and ring states
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] OPT_SEC  = 2'd0;
    localparam logic [1:0] OPT_MIN  = 2'd1;
    localparam logic [1:0] OPT_HOUR = 2'd2;
    localparam logic [1:0] OPT_NONE = 2'd3;

    localparam logic [7:0] MAX_SEC  = 8'h59;
    localparam logic [7:0] MAX_MIN  = 8'h59;
    localparam logic [7:0] MAX_HOUR = 8'h23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_t;

endpackage

// File: rtl/bcd_field_step.sv
// rtl/bcd_field_step.sv - two-digit BCD +1/-1 with wrap at a programmable maximum
module bcd_field_step
    import clock_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] max_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    bcd_t hi;
    bcd_t lo;

    assign hi = value[7:4];
    assign lo = value[3:0];

    // Step the field; simultaneous inc and dec cancel out
    always_comb begin
        result = value;
        if (inc && !dec) begin
            if (value >= max_val) begin
                result = 8'h00;
            end else if (lo == 4'd9) begin
                result = {hi + 4'd1, 4'd0};
            end else begin
                result = {hi, lo + 4'd1};
            end
        end else if (dec && !inc) begin
            if (value == 8'h00) begin
                result = max_val;
            end else if (lo == 4'd0) begin
                result = {hi - 4'd1, 4'd9};
            end else begin
                result = {hi, lo - 4'd1};
            end
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-alarm BCD store with per-field editing and ring/snooze control
module alarm_bank
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  edit_en,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [1:0]            option,
    input  logic                  inc_pulse,
    input  logic                  dec_pulse,
    input  logic                  en_toggle,
    input  logic [23:0]           cur_time,
    input  logic                  sec_tick,
    input  logic                  stop_key,
    input  logic                  snooze_key,
    output logic [23:0]           disp_time,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  ring,
    output logic                  snoozing,
    output logic [SEL_W-1:0]      ring_id
);

    localparam logic [9:0] RING_LAST   = 10'(RING_SECS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);

    logic [23:0]      alarm_time [NUM_ALARMS];
    logic [23:0]      sel_time;
    logic             sel_en;
    logic             sel_valid;
    logic [7:0]       field;
    logic [7:0]       field_max;
    logic [7:0]       field_next;
    logic [23:0]      new_time;
    logic             edit_ok;
    logic             field_wr;
    logic             disable_hit;
    logic             match_hit;
    logic [SEL_W-1:0] match_idx;
    ring_state_t      state;
    logic [9:0]       cnt;

    // Select the addressed alarm; an out-of-range index reads as all zero and is not editable
    always_comb begin
        sel_time  = '0;
        sel_en    = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_sel == SEL_W'(i)) begin
                sel_time  = alarm_time[i];
                sel_en    = alarm_en[i];
                sel_valid = 1'b1;
            end
        end
    end

    assign disp_time = sel_time;
    assign edit_ok   = edit_en && sel_valid;
    assign field_wr  = edit_ok && (inc_pulse ^ dec_pulse) && (option != OPT_NONE);

    // Pick the field being edited and its wrap limit
    always_comb begin
        field     = 8'h00;
        field_max = MAX_SEC;
        case (option)
            OPT_SEC:  begin field = sel_time[7:0];   field_max = MAX_SEC;  end
            OPT_MIN:  begin field = sel_time[15:8];  field_max = MAX_MIN;  end
            OPT_HOUR: begin field = sel_time[23:16]; field_max = MAX_HOUR; end
            default:  begin field = 8'h00;           field_max = MAX_SEC;  end
        endcase
    end

    bcd_field_step u_step (
        .value   (field),
        .max_val (field_max),
        .inc     (inc_pulse),
        .dec     (dec_pulse),
        .result  (field_next)
    );

    // Splice the stepped field back into the selected alarm time
    always_comb begin
        new_time = sel_time;
        case (option)
            OPT_SEC:  new_time[7:0]   = field_next;
            OPT_MIN:  new_time[15:8]  = field_next;
            OPT_HOUR: new_time[23:16] = field_next;
            default:  new_time        = sel_time;
        endcase
    end

    // Alarm time and enable storage, written only by accepted edit pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_time[i] <= '0;
            end
            alarm_en <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (edit_ok && alarm_sel == SEL_W'(i)) begin
                    if (field_wr) begin
                        alarm_time[i] <= new_time;
                    end
                    if (en_toggle) begin
                        alarm_en[i] <= ~alarm_en[i];
                    end
                end
            end
        end
    end

    // Lowest-index enabled alarm whose time equals the running time
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && alarm_time[i] == cur_time) begin
                match_hit = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    // Turning off the alarm that is ringing or snoozing cancels it
    assign disable_hit = edit_ok && en_toggle && sel_en && (alarm_sel == ring_id);

    // Ring/snooze state machine; counter counts sec_ticks spent in the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ring_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sec_tick && match_hit) begin
                        state   <= RING;
                        ring_id <= match_idx;
                        cnt     <= '0;
                    end
                end
                RING: begin
                    if (disable_hit || stop_key) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (snooze_key) begin
                        state <= SNOOZE;
                        cnt   <= '0;
                    end else if (sec_tick) begin
                        if (cnt == RING_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (disable_hit || stop_key) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (sec_tick) begin
                        if (cnt == SNOOZE_LAST) begin
                            state <= RING;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ring     = (state == RING);
    assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - scoreboard bench for alarm_bank with directed vectors
module tb_alarm_bank;

    localparam int NA = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          edit_en;
    logic [SW-1:0] alarm_sel;
    logic [1:0]    option;
    logic          inc_pulse;
    logic          dec_pulse;
    logic          en_toggle;
    logic [23:0]   cur_time;
    logic          sec_tick;
    logic          stop_key;
    logic          snooze_key;
    logic [23:0]   disp_time;
    logic [NA-1:0] alarm_en;
    logic          ring;
    logic          snoozing;
    logic [SW-1:0] ring_id;

    typedef struct {
        string         name;
        logic [23:0]   disp;
        logic [NA-1:0] en;
        logic          ring;
        logic          snz;
        logic [SW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alarm_bank #(
        .NUM_ALARMS  (NA),
        .RING_SECS   (3),
        .SNOOZE_SECS (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .edit_en    (edit_en),
        .alarm_sel  (alarm_sel),
        .option     (option),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .en_toggle  (en_toggle),
        .cur_time   (cur_time),
        .sec_tick   (sec_tick),
        .stop_key   (stop_key),
        .snooze_key (snooze_key),
        .disp_time  (disp_time),
        .alarm_en   (alarm_en),
        .ring       (ring),
        .snoozing   (snoozing),
        .ring_id    (ring_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Monitor: pop and compare every queued expectation on the falling edge
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({disp_time, alarm_en, ring, snoozing, ring_id} !== {e.disp, e.en, e.ring, e.snz, e.id}) begin
                bad++;
                $display("FAIL %s: got disp=%h en=%b ring=%b snz=%b id=%0d, want disp=%h en=%b ring=%b snz=%b id=%0d",
                         e.name, disp_time, alarm_en, ring, snoozing, ring_id,
                         e.disp, e.en, e.ring, e.snz, e.id);
            end
        end
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        en_toggle  = 1'b0;
        sec_tick   = 1'b0;
        stop_key   = 1'b0;
        snooze_key = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [23:0] d, input logic [NA-1:0] en,
                              input logic r, input logic s, input logic [SW-1:0] id);
        exp_t e;
        e.name = name; e.disp = d; e.en = en; e.ring = r; e.snz = s; e.id = id;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic tick(input logic [23:0] t);
        cur_time = t;
        sec_tick = 1'b1;
        clk_step();
    endtask

    initial begin
        rst_n = 1'b0; edit_en = 1'b0; alarm_sel = '0; option = 2'd3;
        inc_pulse = 1'b0; dec_pulse = 1'b0; en_toggle = 1'b0;
        cur_time = '0; sec_tick = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        expect_out("reset", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Hour field of alarm 2 through a full day of increments
        edit_en = 1'b1; alarm_sel = 2'd2; option = 2'd2;
        for (int k = 1; k <= 24; k++) begin
            inc_pulse = 1'b1;
            clk_step();
            expect_out($sformatf("hour_inc_%0d", k), {to_bcd(k % 24), 16'h0000}, 4'b0000, 1'b0, 1'b0, 2'd0);
        end
        alarm_sel = 2'd0; expect_out("other_0", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        alarm_sel = 2'd1; expect_out("other_1", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        alarm_sel = 2'd3; expect_out("other_3", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);

        // Sec/min wrap, cancelling pulses, option none, edit disabled
        alarm_sel = 2'd2; option = 2'd0; dec_pulse = 1'b1; clk_step();
        expect_out("sec_dec_wrap", 24'h000059, 4'b0000, 1'b0, 1'b0, 2'd0);
        inc_pulse = 1'b1; dec_pulse = 1'b1; clk_step();
        expect_out("inc_dec_same", 24'h000059, 4'b0000, 1'b0, 1'b0, 2'd0);
        option = 2'd3; inc_pulse = 1'b1; clk_step();
        expect_out("opt_none", 24'h000059, 4'b0000, 1'b0, 1'b0, 2'd0);
        option = 2'd1; dec_pulse = 1'b1; clk_step();
        expect_out("min_dec_wrap", 24'h005959, 4'b0000, 1'b0, 1'b0, 2'd0);
        option = 2'd0; inc_pulse = 1'b1; clk_step();
        expect_out("sec_inc_wrap", 24'h005900, 4'b0000, 1'b0, 1'b0, 2'd0);
        edit_en = 1'b0; option = 2'd2; inc_pulse = 1'b1; clk_step();
        expect_out("edit_off", 24'h005900, 4'b0000, 1'b0, 1'b0, 2'd0);

        // Alarms 1 and 3 at 07:30:00, both enabled
        edit_en = 1'b1; alarm_sel = 2'd1; option = 2'd2;
        repeat (7) begin inc_pulse = 1'b1; clk_step(); end
        option = 2'd1;
        repeat (30) begin inc_pulse = 1'b1; clk_step(); end
        expect_out("a1_set", 24'h073000, 4'b0000, 1'b0, 1'b0, 2'd0);
        alarm_sel = 2'd3; option = 2'd2;
        repeat (7) begin inc_pulse = 1'b1; clk_step(); end
        option = 2'd1;
        repeat (29) begin inc_pulse = 1'b1; clk_step(); end
        inc_pulse = 1'b1; en_toggle = 1'b1; clk_step();
        expect_out("a3_inc_and_en", 24'h073000, 4'b1000, 1'b0, 1'b0, 2'd0);
        alarm_sel = 2'd1; en_toggle = 1'b1; clk_step();
        expect_out("a1_en", 24'h073000, 4'b1010, 1'b0, 1'b0, 2'd0);

        // Match, auto-stop after three ticks, re-trigger on the next day
        edit_en = 1'b0;
        tick(24'h072959); expect_out("no_match", 24'h073000, 4'b1010, 1'b0, 1'b0, 2'd0);
        tick(24'h073000); expect_out("match_low", 24'h073000, 4'b1010, 1'b1, 1'b0, 2'd1);
        tick(24'h073001);
        tick(24'h073002); expect_out("ring_tick2", 24'h073000, 4'b1010, 1'b1, 1'b0, 2'd1);
        tick(24'h073003); expect_out("ring_auto_stop", 24'h073000, 4'b1010, 1'b0, 1'b0, 2'd1);
        tick(24'h073004); expect_out("idle_hold", 24'h073000, 4'b1010, 1'b0, 1'b0, 2'd1);
        tick(24'h073000); expect_out("next_day", 24'h073000, 4'b1010, 1'b1, 1'b0, 2'd1);

        // Snooze for five ticks then ring again; stop beats snooze
        snooze_key = 1'b1; clk_step();
        expect_out("snooze", 24'h073000, 4'b1010, 1'b0, 1'b1, 2'd1);
        repeat (4) tick(24'h073000);
        expect_out("snooze_4", 24'h073000, 4'b1010, 1'b0, 1'b1, 2'd1);
        tick(24'h073000); expect_out("re_ring", 24'h073000, 4'b1010, 1'b1, 1'b0, 2'd1);
        stop_key = 1'b1; snooze_key = 1'b1; clk_step();
        expect_out("stop_wins", 24'h073000, 4'b1010, 1'b0, 1'b0, 2'd1);

        // Disabling the ringing alarm cancels it; the other alarm then wins
        tick(24'h073000); expect_out("ring_again", 24'h073000, 4'b1010, 1'b1, 1'b0, 2'd1);
        edit_en = 1'b1; en_toggle = 1'b1; clk_step();
        expect_out("disable_cancel", 24'h073000, 4'b1000, 1'b0, 1'b0, 2'd1);
        tick(24'h073000); expect_out("ring_a3", 24'h073000, 4'b1000, 1'b1, 1'b0, 2'd3);
        snooze_key = 1'b1; clk_step();
        expect_out("snooze_a3", 24'h073000, 4'b1000, 1'b0, 1'b1, 2'd3);
        alarm_sel = 2'd3; option = 2'd2; inc_pulse = 1'b1; clk_step();
        expect_out("edit_in_snooze", 24'h083000, 4'b1000, 1'b0, 1'b1, 2'd3);

        // Asynchronous reset mid-snooze
        rst_n = 1'b0; edit_en = 1'b0;
        expect_out("reset_mid", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1; alarm_sel = 2'd1;
        expect_out("settings_lost", 24'h0, 4'b0000, 1'b0, 1'b0, 2'd0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
